// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and MEM-stage data access.
// Optional access counters (icnt/dcnt) are enabled by defining MEM_ARBITER_STATS_EN.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
`ifdef MEM_ARBITER_STATS_EN
    output logic [15:0]       icnt,
    output logic [15:0]       dcnt,
`endif
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t     state_r, state_s;
    logic [3:0] scnt_r, scnt_s;
    logic       dreq_s, dcomp_s, icomp_s;

    assign dreq_s = dREN | dWEN;
    assign iload  = ramload;
    assign dload  = ramload;

    // State and starve counter registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r <= IDLE;
            scnt_r  <= 4'd0;
        end else begin
            state_r <= state_s;
            scnt_r  <= scnt_s;
        end
    end

    // Next-state, RAM strobes and stall outputs.
    always_comb begin
        state_s  = state_r;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = {ADDR_W{1'b0}};
        ramstore = {WORD_W{1'b0}};
        iwait    = iREN;
        dwait    = dreq_s;
        dcomp_s  = 1'b0;
        icomp_s  = 1'b0;
        case (state_r)
            IDLE: begin
                // Starvation guard outranks the normal data-first priority.
                if (iREN && (scnt_r == SMAX)) begin
                    state_s = IGNT;
                end else if (dreq_s) begin
                    state_s = DGNT;
                end else if (iREN) begin
                    state_s = IGNT;
                end else begin
                    state_s = IDLE;
                end
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~ramready;
                if (ramready) begin
                    dcomp_s = 1'b1;
                    state_s = IDLE;
                end else if (!dreq_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DGNT;
                end
            end
            IGNT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                iwait   = ~ramready;
                if (ramready) begin
                    icomp_s = 1'b1;
                    state_s = IDLE;
                end else if (!iREN) begin
                    state_s = IDLE;
                end else begin
                    state_s = IGNT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Starve counter: counts data wins over a waiting fetch, saturating.
    always_comb begin
        scnt_s = scnt_r;
        if (dcomp_s) begin
            if (iREN) begin
                scnt_s = (scnt_r < SMAX) ? (scnt_r + 4'd1) : SMAX;
            end else begin
                scnt_s = 4'd0;
            end
        end else if (icomp_s) begin
            scnt_s = 4'd0;
        end else begin
            scnt_s = scnt_r;
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] icnt_r, dcnt_r;

    // Saturating completion counters; aborts never reach a completion.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            icnt_r <= 16'd0;
            dcnt_r <= 16'd0;
        end else begin
            if (icomp_s && (icnt_r != 16'hFFFF)) begin
                icnt_r <= icnt_r + 16'd1;
            end
            if (dcomp_s && (dcnt_r != 16'hFFFF)) begin
                dcnt_r <= dcnt_r + 16'd1;
            end
        end
    end

    assign icnt = icnt_r;
    assign dcnt = dcnt_r;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter; inputs change 2ns after the rising edge,
// outputs are sampled 1ns later.
module tb_mem_arbiter;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN, ramready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] icnt, dcnt;
    logic [15:0] icnt_save;
`endif

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(32), .WORD_W(32), .STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
`ifdef MEM_ARBITER_STATS_EN
        .icnt(icnt), .dcnt(dcnt),
`endif
        .ramload(ramload), .ramready(ramready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_inputs;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset();
        iREN = 1'b1; dREN = 1'b1;
        #1;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL rst_ramREN got %b exp 0", ramREN); end
        checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL rst_ramWEN got %b exp 0", ramWEN); end
        checks++; if (ramaddr !== 32'h0) begin failures++; $display("FAIL rst_ramaddr got %h exp 0", ramaddr); end
        checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL rst_waits got i=%b d=%b exp 1 1", iwait, dwait); end
        checks++; if (dut.scnt_r !== 4'd0) begin failures++; $display("FAIL rst_scnt got %0d exp 0", dut.scnt_r); end
`ifdef MEM_ARBITER_STATS_EN
        checks++; if (icnt !== 16'd0 || dcnt !== 16'd0) begin failures++; $display("FAIL rst_cnts got %0d %0d exp 0 0", icnt, dcnt); end
`endif
        apply_reset();
    endtask

    task automatic test_single_read;
        dREN = 1'b1; daddr = 32'h100; ramready = 1'b1; ramload = 32'hDEADBEEF;
        #1;
        checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL rd_c1 got ramREN=%b dwait=%b exp 0 1", ramREN, dwait); end
        tick();
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin failures++; $display("FAIL rd_c2_ram got ramREN=%b addr=%h exp 1 100", ramREN, ramaddr); end
        checks++; if (dwait !== 1'b0 || dload !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_c2_data got dwait=%b dload=%h exp 0 deadbeef", dwait, dload); end
        tick();
        dREN = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin failures++; $display("FAIL rd_c3_idle got ramREN=%b addr=%h exp 0 0", ramREN, ramaddr); end
        clear_inputs();
    endtask

    task automatic test_simultaneous;
        iREN = 1'b1; iaddr = 32'h40; dWEN = 1'b1; daddr = 32'h200;
        dstore = 32'hCAFE0001; ramready = 1'b1; ramload = 32'h1234ABCD;
        #1;
        checks++; if (iwait !== 1'b1 || dwait !== 1'b1 || ramWEN !== 1'b0) begin failures++; $display("FAIL sim_c1 got iw=%b dw=%b wen=%b exp 1 1 0", iwait, dwait, ramWEN); end
        tick();
        #1;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h200 || ramstore !== 32'hCAFE0001) begin failures++; $display("FAIL sim_dgnt got wen=%b ren=%b addr=%h st=%h exp 1 0 200 cafe0001", ramWEN, ramREN, ramaddr, ramstore); end
        checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL sim_dgnt_wait got dw=%b iw=%b exp 0 1", dwait, iwait); end
        tick();
        dWEN = 1'b0;
        #1;
        checks++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin failures++; $display("FAIL sim_idle got iw=%b ren=%b exp 1 0", iwait, ramREN); end
        checks++; if (dut.scnt_r !== 4'd1) begin failures++; $display("FAIL sim_scnt got %0d exp 1", dut.scnt_r); end
        tick();
        #1;
        checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || iwait !== 1'b0 || iload !== 32'h1234ABCD) begin failures++; $display("FAIL sim_ignt got ren=%b wen=%b addr=%h iw=%b il=%h exp 1 0 40 0 1234abcd", ramREN, ramWEN, ramaddr, iwait, iload); end
        tick();
        iREN = 1'b0;
        #1;
        checks++; if (dut.scnt_r !== 4'd0 || ramREN !== 1'b0) begin failures++; $display("FAIL sim_end got scnt=%0d ren=%b exp 0 0", dut.scnt_r, ramREN); end
        clear_inputs();
    endtask

    task automatic test_write_priority;
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h280; dstore = 32'h55AA55AA; ramready = 1'b1;
        tick();
        #1;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h55AA55AA) begin failures++; $display("FAIL wpri got wen=%b ren=%b st=%h exp 1 0 55aa55aa", ramWEN, ramREN, ramstore); end
        tick();
        clear_inputs();
    endtask

    task automatic test_starvation;
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h300; ramready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300 || dwait !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL starve_d%0d got ren=%b addr=%h dw=%b iw=%b exp 1 300 0 1", k, ramREN, ramaddr, dwait, iwait); end
            tick();
        end
        #1;
        checks++; if (dut.scnt_r !== 4'd4) begin failures++; $display("FAIL starve_scnt4 got %0d exp 4", dut.scnt_r); end
        tick();
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h80 || iwait !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL starve_ignt got ren=%b addr=%h iw=%b dw=%b exp 1 80 0 1", ramREN, ramaddr, iwait, dwait); end
        tick();
        #1;
        checks++; if (dut.scnt_r !== 4'd0) begin failures++; $display("FAIL starve_scnt0 got %0d exp 0", dut.scnt_r); end
        tick();
        #1;
        checks++; if (ramaddr !== 32'h300 || dwait !== 1'b0) begin failures++; $display("FAIL starve_resume got addr=%h dw=%b exp 300 0", ramaddr, dwait); end
        tick();
        clear_inputs();
        apply_reset();
    endtask

    task automatic test_wait_states;
        int dw_cnt;
        dw_cnt = 0;
        dREN = 1'b1; daddr = 32'h400; ramready = 1'b0;
        #1;
        if (dwait === 1'b1) dw_cnt++;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) ramready = 1'b1;
            #1;
            if (dwait === 1'b1) dw_cnt++;
            checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h400) begin failures++; $display("FAIL ws_strobe%0d got ren=%b wen=%b addr=%h exp 1 0 400", k, ramREN, ramWEN, ramaddr); end
        end
        checks++; if (dw_cnt !== 4 || dwait !== 1'b0) begin failures++; $display("FAIL ws_dwait got cycles=%0d final=%b exp 4 0", dw_cnt, dwait); end
        tick();
        dREN = 1'b0; ramready = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL ws_idle got ren=%b exp 0", ramREN); end
        clear_inputs();
    endtask

    task automatic test_abort;
`ifdef MEM_ARBITER_STATS_EN
        icnt_save = icnt;
`endif
        iREN = 1'b1; iaddr = 32'h500; ramready = 1'b0;
        tick();
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h500 || iwait !== 1'b1) begin failures++; $display("FAIL ab_ignt got ren=%b addr=%h iw=%b exp 1 500 1", ramREN, ramaddr, iwait); end
        iREN = 1'b0;
        tick();
        #1;
        checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || iwait !== 1'b0) begin failures++; $display("FAIL ab_idle got ren=%b addr=%h iw=%b exp 0 0 0", ramREN, ramaddr, iwait); end
        ramready = 1'b1;
        tick();
        #1;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL ab_stay got ren=%b exp 0", ramREN); end
`ifdef MEM_ARBITER_STATS_EN
        checks++; if (icnt !== icnt_save) begin failures++; $display("FAIL ab_icnt got %0d exp %0d", icnt, icnt_save); end
`endif
        clear_inputs();
    endtask

    task automatic test_reset_mid_access;
        iREN = 1'b1; iaddr = 32'h700; dREN = 1'b1; daddr = 32'h610; ramready = 1'b1;
        tick();
        tick();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b1; daddr = 32'h600; dstore = 32'h0BADF00D; ramready = 1'b0;
        tick();
        #1;
        checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h600 || dut.scnt_r !== 4'd1) begin failures++; $display("FAIL rm_dgnt got wen=%b addr=%h scnt=%0d exp 1 600 1", ramWEN, ramaddr, dut.scnt_r); end
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        #1;
        checks++; if (ramWEN !== 1'b0 || dwait !== 1'b1 || dut.scnt_r !== 4'd0) begin failures++; $display("FAIL rm_idle got wen=%b dw=%b scnt=%0d exp 0 1 0", ramWEN, dwait, dut.scnt_r); end
        tick();
        ramready = 1'b1;
        #1;
        checks++; if (ramWEN !== 1'b1 || ramstore !== 32'h0BADF00D || dwait !== 1'b0) begin failures++; $display("FAIL rm_regrant got wen=%b st=%h dw=%b exp 1 0badf00d 0", ramWEN, ramstore, dwait); end
        tick();
        clear_inputs();
    endtask

    initial begin
        nRST = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write_priority();
        test_starvation();
        test_wait_states();
        test_abort();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port RAM arbiter shared by the instruction-fetch path and the MEM-stage data path of the pipelined CPU.
- Data accesses have priority over instruction fetches.
- A starvation guard forces an instruction grant after a run of consecutive data grants.
- The block sequences each access with a small FSM and holds the requesting stage with its wait signal until the RAM reports completion.

Parameters:
- ADDR_W, 32, address width of both requesters and the RAM.
- WORD_W, 32, data word width.
- STARVE_MAX, 4, number of consecutive data completions while iREN is pending before the next grant is forced to instruction; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, synchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  instruction stall; 0 only in the cycle the fetch completes.
- iload  out  WORD_W  instruction data; equals ramload.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  WORD_W  write data.
- dwait  out  1  data stall; 0 only in the completion cycle.
- dload  out  WORD_W  read data; equals ramload.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramready  in  1  RAM access complete this cycle.

Behaviour:
- Storage: a 2-bit state register and a 4-bit starve counter `scnt`. Everything else is combinational from state and inputs.
- FSM states: IDLE, DGNT, IGNT.
- Synchronous reset: when nRST=0 at a clock edge, state becomes IDLE and scnt becomes 0. This also applies mid-access: the RAM strobes drop the next cycle and no completion is signalled. Any pending request is re-arbitrated later from IDLE.
- IDLE outputs:
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=iREN; dwait=(dREN|dWEN).
- IDLE transitions, evaluated in this order:
  - iREN=1 and scnt==STARVE_MAX: go to IGNT.
  - dREN|dWEN: go to DGNT.
  - iREN: go to IGNT.
  - Otherwise stay in IDLE.
- DGNT outputs:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN, ramREN=dREN&~dWEN. Writes win if both strobes are asserted.
  - dwait=~ramready; iwait=iREN.
- DGNT transitions:
  - ramready=1: complete the access and go to IDLE.
  - Data request withdrawn (dREN|dWEN=0) before ramready: abort, go to IDLE, no completion.
- IGNT outputs:
  - ramaddr=iaddr, ramREN=1, ramWEN=0.
  - iwait=~ramready; dwait=(dREN|dWEN).
- IGNT transitions:
  - Completes on ramready and goes to IDLE.
  - iREN dropping before ramready aborts the access and goes to IDLE.
- Latency: minimum 2 cycles per access (IDLE arbitration cycle plus one grant cycle with ramready=1). The grant cycle repeats while ramready=0.
- Back-to-back requests always pass through IDLE between accesses.
- Starve counter updates:
  - On a data completion with iREN=1: scnt+1, saturating at STARVE_MAX.
  - On a data completion with iREN=0: scnt=0.
  - On an instruction completion: scnt=0.
  - Unchanged on aborts.
- ramready seen while in IDLE is ignored.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- When defined, adds two output ports, icnt and dcnt, each 16 bits wide.
  - They count completed instruction and data accesses respectively.
  - Both saturate at 16'hFFFF.
  - Both clear on reset.
  - Aborted accesses are not counted.
- When not defined, neither port nor its logic exists and behaviour is otherwise identical.

Test Plan:
- Single read: dREN=1, daddr=0x100; ramready held 1 → ramREN=1, ramaddr=0x100 in cycle 2. dwait=0 and dload=ramload=0xDEADBEEF in cycle 2. State back to IDLE in cycle 3.
- Simultaneous requests: iREN=1 and dWEN=1 asserted together, ramready=1 → data write granted first with ramWEN=1, ramstore=dstore. The instruction fetch completes 2 cycles later and iwait=1 throughout.
- Starvation: iREN held, dREN held continuously, STARVE_MAX=4 → four data completions, then one instruction grant (ramREN=1, ramaddr=iaddr), then data resumes. scnt returns to 0.
- Wait states: dREN=1 with ramready=0 for 3 cycles then 1 → dwait=1 for 4 cycles. RAM strobes are stable for 4 cycles and ramaddr does not change.
- Abort: in IGNT with ramready=0, drop iREN → next cycle IDLE with ramREN=0. No completion; with the stats macro defined, icnt is unchanged.
- Reset mid-access: nRST=0 for one edge during DGNT → next cycle IDLE, ramWEN=0, scnt=0. A still-pending dWEN is re-granted 2 cycles later.
